// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// RV32I load/store unit between the pipeline and a word-addressed memory.
// Latency accept->resp_valid: fault 1, load 2, SW 2, SB/SH 3 (read-modify-write).
// Backpressure: req_ready only in IDLE; requests while busy are ignored, not queued.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, STORE, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

   state_t      state;
   req_t        cur;

   logic        legal_f3;
   logic        misaligned;
   logic        out_of_range;
   logic        req_fault;
   logic [31:0] word_idx;

   logic [31:0] lane;
   logic [31:0] load_data;
   logic [31:0] ins_data;
   logic [31:0] ins_mask;
   logic [31:0] merged;

   // Classify the incoming request: illegal width code, misalignment, range.
   always_comb begin
      word_idx = {2'b00, req_addr[31:2]};
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
         3'b100, 3'b101:         legal_f3 = !req_we;
         default:                legal_f3 = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      out_of_range = (word_idx >= MEM_WORDS_U);
      req_fault    = !legal_f3 || misaligned || out_of_range;
   end

   // Pick the addressed lane out of the read word and extend it.
   always_comb begin
      lane = mem_rd >> {cur.addr[1:0], 3'b000};
      case (cur.funct3)
         3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_data = {24'h0, lane[7:0]};
         3'b101:  load_data = {16'h0, lane[15:0]};
         default: load_data = mem_rd;
      endcase
   end

   // Splice the store data into the word read back from memory.
   always_comb begin
      case (cur.funct3[1:0])
         2'b00: begin
            ins_mask = 32'h0000_00FF << {cur.addr[1:0], 3'b000};
            ins_data = {4{cur.wdata[7:0]}};
         end
         2'b01: begin
            ins_mask = 32'h0000_FFFF << {cur.addr[1], 4'b0000};
            ins_data = {2{cur.wdata[15:0]}};
         end
         default: begin
            ins_mask = 32'hFFFF_FFFF;
            ins_data = cur.wdata;
         end
      endcase
      merged = (mem_rd & ~ins_mask) | (ins_data & ins_mask);
   end

   // Access sequencer; every output is a register so reset clears them at once.
   // mem_wd doubles as the merge register: it is loaded with the spliced word
   // at the end of RMW_READ and presented to memory during STORE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cur        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_fault <= 1'b0;
         mem_a      <= 32'h0;
         mem_we     <= 1'b0;
         mem_wd     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cur       <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                  req_ready <= 1'b0;
                  if (req_fault) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                  end else if (!req_we) begin
                     state <= LOAD;
                     mem_a <= {req_addr[31:2], 2'b00};
                  end else if (req_funct3[1]) begin
                     state  <= STORE;
                     mem_a  <= {req_addr[31:2], 2'b00};
                     mem_we <= 1'b1;
                     mem_wd <= req_wdata;
                  end else begin
                     state <= RMW_READ;
                     mem_a <= {req_addr[31:2], 2'b00};
                  end
               end
            end
            LOAD: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= cur.we ? 32'h0 : load_data;
               mem_a      <= 32'h0;
            end
            RMW_READ: begin
               state  <= STORE;
               mem_a  <= {cur.addr[31:2], 2'b00};
               mem_we <= 1'b1;
               mem_wd <= merged;
            end
            STORE: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               mem_a      <= 32'h0;
               mem_we     <= 1'b0;
               mem_wd     <= 32'h0;
            end
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= 32'h0;
               resp_fault <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= 32'h0;
               resp_fault <= 1'b0;
               mem_a      <= 32'h0;
               mem_we     <= 1'b0;
               mem_wd     <= 32'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Bench for load_store_unit: byte-level reference memory, directed and random accesses.
// Checks data, fault, latency, write pulses, idle outputs and reset abandonment.
// Drives at negedge / #1 after posedge, samples at negedge.
module tb_load_store_unit;

   localparam int MW = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem [MW];
   logic        init_we = 1'b0;
   logic [5:0]  init_idx = 6'd0;
   logic [31:0] init_wd = 32'h0;

   logic [7:0]  ref_bytes [MW*4];

   int n_checks = 0;
   int n_errors = 0;

   load_store_unit #(.MEM_WORDS(MW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Attached memory: combinational read, write on the clock edge.
   assign mem_rd = (mem_a[31:8] == 24'h0) ? mem[mem_a[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_a[31:8] == 24'h0) mem[mem_a[7:2]] <= mem_wd;
      end else if (init_we) begin
         mem[init_idx] <= init_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
   endfunction

   // Reference: byte-addressed little-endian memory following the ISA rules.
   task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] er, output logic ef,
                            output int elat, output int ew);
      int  n;
      bit  legal;
      n = 1 << f3[1:0];
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      ef = !legal || ((addr % n) != 0) || ((addr / 4) >= MW);
      er = 32'h0;
      ew = 0;
      if (ef) begin
         elat = 1;
      end else if (!we) begin
         for (int i = 0; i < n; i++) er = er | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
         if (!f3[2] && n < 4 && er[8*n-1]) er = er | ~((32'd1 << (8 * n)) - 32'd1);
         elat = 2;
      end else begin
         for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wd[8*i +: 8];
         elat = (n == 4) ? 2 : 3;
         ew = 1;
      end
   endtask

   // One complete access starting at a negedge with the unit idle; ends at the idle negedge.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input string tag, output logic [31:0] got);
      logic [31:0] er, last_wd, last_wa, got_rd;
      logic        ef, got_f, wd_clean;
      int          elat, ew, lat, nwe;
      ref_model(we, f3, addr, wd, er, ef, elat, ew);
      check({tag, ":ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; nwe = 0; last_wd = 32'h0; last_wa = 32'h0; got_rd = 32'h0; got_f = 1'b0;
      wd_clean = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_we) begin
            nwe++;
            last_wd = mem_wd;
            last_wa = mem_a;
         end else if (mem_wd != 32'h0) begin
            wd_clean = 1'b0;
         end
         if (resp_valid) begin
            lat = c;
            got_rd = resp_rdata;
            got_f = resp_fault;
            break;
         end
      end
      got = got_rd;
      check({tag, ":latency"}, 32'(lat), 32'(elat));
      check({tag, ":rdata"}, got_rd, er);
      check({tag, ":fault"}, 32'(got_f), 32'(ef));
      check({tag, ":we_pulses"}, 32'(nwe), 32'(ew));
      check({tag, ":wd_zero_when_idle"}, 32'(wd_clean), 32'd1);
      if (ew != 0) begin
         check({tag, ":mem_wd"}, last_wd, ref_word(int'(addr[7:2])));
         check({tag, ":mem_a"}, last_wa, {addr[31:2], 2'b00});
      end
      @(negedge clk);
      check({tag, ":resp_drop"}, {resp_rdata[30:0], resp_valid}, 32'h0);
      check({tag, ":fault_drop"}, 32'(resp_fault), 32'd0);
      check({tag, ":idle_mem"}, mem_a | mem_wd | 32'(mem_we), 32'h0);
      check({tag, ":mem_word"}, mem[addr[7:2]], ref_word(int'(addr[7:2])));
   endtask

   initial begin
      logic [31:0] got, w, er1, er2, swd;
      logic        ef1, ef2;
      int          el1, el2, ew1, ew2, seen_v, seen_we;
      logic        we_r;
      logic [2:0]  f3_r;
      logic [31:0] a_r;

      #1 reset = 1'b1;
      #1;
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_resp", {resp_rdata[30:0], resp_valid} | 32'(resp_fault), 32'h0);
      check("reset_mem", mem_a | mem_wd | 32'(mem_we), 32'h0);

      for (int i = 0; i < MW; i++) begin
         @(negedge clk);
         if (i == 12)     w = 32'h0000_0003;
         else if (i == 3) w = 32'h0064_A423;
         else             w = $urandom;
         init_we = 1'b1; init_idx = 6'(i); init_wd = w;
         for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = w[8*b +: 8];
      end
      @(negedge clk);
      init_we = 1'b0;
      reset = 1'b0;

      do_access(1'b0, 3'b010, 32'h30, 32'h0, "lw_0x30", got);
      check("lw_0x30_value", got, 32'h0000_0003);
      do_access(1'b0, 3'b000, 32'h0E, 32'h0, "lb_0x0e", got);
      check("lb_0x0e_value", got, 32'h0000_0064);
      do_access(1'b0, 3'b001, 32'h0C, 32'h0, "lh_0x0c", got);
      check("lh_0x0c_value", got, 32'hFFFF_A423);
      do_access(1'b0, 3'b101, 32'h0C, 32'h0, "lhu_0x0c", got);
      check("lhu_0x0c_value", got, 32'h0000_A423);
      do_access(1'b0, 3'b100, 32'h0F, 32'h0, "lbu_0x0f", got);
      check("lbu_0x0f_value", got, 32'h0000_0000);
      do_access(1'b1, 3'b000, 32'h0D, 32'h0000_00FF, "sb_0x0d", got);
      check("sb_0x0d_word", mem[3], 32'h0064_FF23);
      do_access(1'b0, 3'b010, 32'h0C, 32'h0, "lw_after_sb", got);
      check("lw_after_sb_value", got, 32'h0064_FF23);
      do_access(1'b0, 3'b010, 32'h32, 32'h0, "lw_misaligned", got);
      do_access(1'b1, 3'b001, 32'h0F, 32'h1234, "sh_misaligned", got);
      do_access(1'b0, 3'b011, 32'h00, 32'h0, "f3_011", got);
      do_access(1'b0, 3'b010, 32'h100, 32'h0, "lw_out_of_range", got);
      do_access(1'b1, 3'b101, 32'h04, 32'hABCD, "store_f3_101", got);

      // Back-to-back with req_valid held high: LW then SW.
      swd = $urandom;
      ref_model(1'b0, 3'b010, 32'h30, 32'h0, er1, ef1, el1, ew1);
      ref_model(1'b1, 3'b010, 32'h10, swd, er2, ef2, el2, ew2);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
      @(posedge clk);
      #1 req_we = 1'b1; req_addr = 32'h10; req_wdata = swd;
      @(negedge clk);
      check("b2b_busy_ready1", {31'h0, req_ready} | 32'(resp_valid) | 32'(mem_we), 32'h0);
      @(negedge clk);
      check("b2b_lw_valid", 32'(resp_valid), 32'd1);
      check("b2b_lw_rdata", resp_rdata, er1);
      check("b2b_busy_ready2", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("b2b_idle_ready", 32'(req_ready), 32'd1);
      check("b2b_idle_resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_sw_we", 32'(mem_we), 32'd1);
      check("b2b_sw_wd", mem_wd, swd);
      @(negedge clk);
      check("b2b_sw_valid", 32'(resp_valid), 32'd1);
      check("b2b_sw_fault", 32'(resp_fault), 32'(ef2));
      check("b2b_sw_mem", mem[4], ref_word(4));
      @(negedge clk);

      // Reset during RMW_READ of an SH abandons it completely.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0C; req_wdata = 32'hBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_resp", {resp_rdata[30:0], resp_valid} | 32'(resp_fault), 32'h0);
      check("rst_mid_mem", mem_a | mem_wd | 32'(mem_we), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      seen_v = 0; seen_we = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (resp_valid) seen_v++;
         if (mem_we) seen_we++;
      end
      check("rst_no_resp", 32'(seen_v), 32'd0);
      check("rst_no_write", 32'(seen_we), 32'd0);
      check("rst_word3", mem[3], ref_word(3));

      // First accept right after reset release.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      do_access(1'b0, 3'b010, 32'h0C, 32'h0, "first_after_reset", got);

      for (int k = 0; k < 80; k++) begin
         we_r = 1'($urandom_range(0, 1));
         f3_r = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            6:       a_r = 32'($urandom_range(256, 1023));
            7:       a_r = $urandom;
            default: a_r = 32'($urandom_range(0, 255));
         endcase
         do_access(we_r, f3_r, a_r, $urandom, $sformatf("rand%0d", k), got);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the attached data memory; accesses to word index >= MEM_WORDS fault.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline access request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 SHALL have port resp_fault  output  1  misaligned, illegal funct3 or out-of-range access.
REQ-013 SHALL have ports mem_a  output  32, mem_we  output  1, mem_wd  output  32, mem_rd  input  32; these drive a word-addressed memory with combinational read and a synchronous write on the clk edge.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RMW_READ, STORE, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge with req_valid&&req_ready, latching addr, funct3, wdata and we.
REQ-016 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW; every other code faults.
REQ-017 SHALL fault when a halfword has addr[0]=1, a word has addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
REQ-018 On accept, SHALL transition as follows: fault -> RESP; load -> LOAD; SW -> STORE; SB/SH -> RMW_READ.
REQ-019 LOAD SHALL drive mem_a={addr[31:2],2'b00}, capture mem_rd, select the lane by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU) into the response register, then go to RESP.
REQ-020 RMW_READ SHALL capture mem_rd into a merge register, replace only the addressed byte (SB, wdata[7:0]) or halfword (SH, wdata[15:0]), then go to STORE.
REQ-021 STORE SHALL assert mem_we=1 for exactly one cycle with mem_wd equal to the merged word (SB/SH) or wdata (SW), then go to RESP.
REQ-022 RESP SHALL assert resp_valid=1 for exactly one cycle with resp_rdata/resp_fault valid, then go to IDLE.
REQ-023 Accept-to-resp_valid latency SHALL be: fault 1 cycle; load 2 cycles; SW 2 cycles; SB/SH 3 cycles.
REQ-024 In IDLE, SHALL drive mem_a=0, mem_we=0 and mem_wd=0; mem_wd SHALL be 0 whenever mem_we=0.
REQ-025 A faulting access SHALL never assert mem_we.
REQ-026 req_valid asserted while busy SHALL be ignored, with no latch and no side effect; a request held through RESP is accepted in the following IDLE cycle.
REQ-027 resp_rdata and resp_fault SHALL hold their values only while resp_valid=1 and be 0 otherwise.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_a=0, mem_we=0 and mem_wd=0.
REQ-029 Reset mid-operation SHALL abandon the access: no memory write if reset is asserted before the STORE edge, and no response is issued afterward.
REQ-030 After reset deassertion, the first accept SHALL be possible on the first rising clk edge.

Verification
REQ-031 Memory word 12=0x00000003; LW addr 0x30 -> resp_valid 2 cycles after accept, resp_rdata=0x00000003, resp_fault=0.
REQ-032 Word 3=0x0064A423; LB 0x0E -> 0x00000064; LH 0x0C -> 0xFFFFA423; LHU 0x0C -> 0x0000A423; LBU 0x0F -> 0x00000000.
REQ-033 SB addr 0x0D, wdata 0x000000FF -> mem_we high exactly one cycle with mem_wd=0x0064FF23; a subsequent LW 0x0C returns 0x0064FF23; latency 3.
REQ-034 LW 0x32, SH 0x0F, funct3 011 and LW 0x100 (MEM_WORDS=64) -> each gives resp_fault=1, resp_rdata=0, no mem_we, latency 1.
REQ-035 SH 0x0C with reset pulsed during RMW_READ -> mem_we never asserted, no resp_valid, word 3 unchanged, req_ready=1 after reset.
REQ-036 req_valid held high across LW then SW back-to-back -> req_ready low while busy, second request accepted the cycle after RESP, both responses in order.
